// File: rtl/sgpr_sync.sv
// sgpr_sync: copies R1..R(NUM_WORDS-1) between the core register file and the shadow GPR file, one word per cycle, while the core is halted.
// Latency: a request enters HALT on the next edge; after halt_ack_i, COPY takes NUM_WORDS-1 cycles, then a single DONE cycle. Each read-to-write path is combinational.
// Backpressure: waits in HALT for halt_ack_i with no timeout; requests that arrive while busy are dropped, not queued.
module sgpr_sync #(
   parameter int RV32E      = 0,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ckpt_req_i,
   input  logic                  rb_req_i,
   output logic                  halt_req_o,
   input  logic                  halt_ack_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4:0]            core_raddr_o,
   input  logic [DATA_WIDTH-1:0] core_rdata_i,
   output logic [4:0]            core_waddr_o,
   output logic [DATA_WIDTH-1:0] core_wdata_o,
   output logic                  core_we_o,
   output logic [4:0]            sgpr_raddr_o,
   input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
   output logic [4:0]            sgpr_waddr_o,
   output logic [DATA_WIDTH-1:0] sgpr_wdata_o,
   output logic                  sgpr_we_o
);

   localparam int ADDR_WIDTH = (RV32E != 0) ? 4 : 5;
   localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;

   // R0 is hardwired to zero in the core, so the copy starts at R1 and
   // stops on the last register without wrapping back to R0.
   localparam logic [ADDR_WIDTH-1:0] CNT_FIRST = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = ADDR_WIDTH'(NUM_WORDS - 1);

   localparam logic MODE_CKPT = 1'b0;
   localparam logic MODE_RB   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HALT = 2'd1,
      ST_COPY = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   logic                  r_mode;
   logic                  w_mode_nxt;
   logic [4:0]            w_addr;

   // State, copy counter and direction; reset forces IDLE/checkpoint at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_mode  <= MODE_CKPT;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mode  <= w_mode_nxt;
      end
   end

   // Next state, counter and mode; halt_ack_i is only looked at in HALT,
   // so a drop of the ack mid-copy cannot stall or abort the sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mode_nxt  = r_mode;
      case (r_state)
         ST_IDLE: begin
            if (rb_req_i) begin
               w_mode_nxt  = MODE_RB;
               w_state_nxt = ST_HALT;
            end else if (ckpt_req_i) begin
               w_mode_nxt  = MODE_CKPT;
               w_state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            if (halt_ack_i) begin
               w_cnt_nxt   = CNT_FIRST;
               w_state_nxt = ST_COPY;
            end
         end
         ST_COPY: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_FIRST;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode; addresses and data are forced to zero outside COPY so
   // nothing floats or leaks an X from the register files while idle.
   always_comb begin
      halt_req_o   = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      core_raddr_o = '0;
      core_waddr_o = '0;
      core_wdata_o = '0;
      core_we_o    = 1'b0;
      sgpr_raddr_o = '0;
      sgpr_waddr_o = '0;
      sgpr_wdata_o = '0;
      sgpr_we_o    = 1'b0;
      w_addr       = 5'(r_cnt);
      case (r_state)
         ST_IDLE: begin
            busy_o = 1'b0;
         end
         ST_HALT: begin
            busy_o     = 1'b1;
            halt_req_o = 1'b1;
         end
         ST_COPY: begin
            busy_o       = 1'b1;
            halt_req_o   = 1'b1;
            core_raddr_o = w_addr;
            core_waddr_o = w_addr;
            sgpr_raddr_o = w_addr;
            sgpr_waddr_o = w_addr;
            if (r_mode == MODE_RB) begin
               core_wdata_o = sgpr_rdata_i;
               core_we_o    = 1'b1;
            end else begin
               sgpr_wdata_o = core_rdata_i;
               sgpr_we_o    = 1'b1;
            end
         end
         ST_DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sgpr_sync.sv
// Bench for sgpr_sync: two instances (32-entry and RV32E) with register file models in the bench.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled 2 time units after it.
// Expected register contents come from a simple copy model over the bench arrays.
module tb_sgpr_sync;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          ckpt_req, rb_req, halt_ack;
   logic          halt_req, busy, done;
   logic [4:0]    core_raddr, core_waddr, sgpr_raddr, sgpr_waddr;
   logic [DW-1:0] core_rdata, core_wdata, sgpr_rdata, sgpr_wdata;
   logic          core_we, sgpr_we;

   logic          e_ckpt_req, e_rb_req, e_halt_ack;
   logic          e_halt_req, e_busy, e_done;
   logic [4:0]    e_core_raddr, e_core_waddr, e_sgpr_raddr, e_sgpr_waddr;
   logic [DW-1:0] e_core_rdata, e_core_wdata, e_sgpr_rdata, e_sgpr_wdata;
   logic          e_core_we, e_sgpr_we;

   logic [DW-1:0] core_rf [0:31];
   logic [DW-1:0] sgpr_rf [0:31];
   logic [DW-1:0] e_core_rf [0:31];
   logic [DW-1:0] e_sgpr_rf [0:31];
   logic [DW-1:0] exp_core [0:31];
   logic [DW-1:0] exp_sgpr [0:31];

   assign core_rdata   = core_rf[core_raddr];
   assign sgpr_rdata   = sgpr_rf[sgpr_raddr];
   assign e_core_rdata = e_core_rf[e_core_raddr];
   assign e_sgpr_rdata = e_sgpr_rf[e_sgpr_raddr];

   sgpr_sync #(.RV32E(0), .DATA_WIDTH(DW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ckpt_req_i(ckpt_req), .rb_req_i(rb_req),
      .halt_req_o(halt_req), .halt_ack_i(halt_ack),
      .busy_o(busy), .done_o(done),
      .core_raddr_o(core_raddr), .core_rdata_i(core_rdata),
      .core_waddr_o(core_waddr), .core_wdata_o(core_wdata), .core_we_o(core_we),
      .sgpr_raddr_o(sgpr_raddr), .sgpr_rdata_i(sgpr_rdata),
      .sgpr_waddr_o(sgpr_waddr), .sgpr_wdata_o(sgpr_wdata), .sgpr_we_o(sgpr_we)
   );

   sgpr_sync #(.RV32E(1), .DATA_WIDTH(DW)) u_dut_e (
      .clk(clk), .rst_n(rst_n),
      .ckpt_req_i(e_ckpt_req), .rb_req_i(e_rb_req),
      .halt_req_o(e_halt_req), .halt_ack_i(e_halt_ack),
      .busy_o(e_busy), .done_o(e_done),
      .core_raddr_o(e_core_raddr), .core_rdata_i(e_core_rdata),
      .core_waddr_o(e_core_waddr), .core_wdata_o(e_core_wdata), .core_we_o(e_core_we),
      .sgpr_raddr_o(e_sgpr_raddr), .sgpr_rdata_i(e_sgpr_rdata),
      .sgpr_waddr_o(e_sgpr_waddr), .sgpr_wdata_o(e_sgpr_wdata), .sgpr_we_o(e_sgpr_we)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Activity counters, all stepped by tick().
   int          cyc = 0;
   int          n_swe = 0, n_cwe = 0, n_done = 0, n_swe0 = 0, n_cwe0 = 0;
   int          last_we_cyc = 0, done_cyc = 0;
   logic [31:0] sw_mask, cw_mask;
   int          e_swe = 0, e_cwe = 0, e_ndone = 0, e_last_cyc = 0, e_done_cyc = 0;
   logic [31:0] e_mask;

   // One clock: sample outputs, apply the register file writes at the edge.
   task automatic tick();
      logic          s_we, c_we, es_we, ec_we;
      logic [4:0]    s_a, c_a, es_a;
      logic [DW-1:0] s_d, c_d, es_d;
      bit            live;
      #1;
      live  = (rst_n === 1'b1);
      s_we  = sgpr_we;    s_a = sgpr_waddr;   s_d = sgpr_wdata;
      c_we  = core_we;    c_a = core_waddr;   c_d = core_wdata;
      es_we = e_sgpr_we;  es_a = e_sgpr_waddr; es_d = e_sgpr_wdata;
      ec_we = e_core_we;
      if (live) begin
         if (s_we === 1'b1) begin
            n_swe++; sw_mask[s_a] = 1'b1; last_we_cyc = cyc;
            if (s_a == 5'd0) n_swe0++;
         end
         if (c_we === 1'b1) begin
            n_cwe++; cw_mask[c_a] = 1'b1; last_we_cyc = cyc;
            if (c_a == 5'd0) n_cwe0++;
         end
         if (done === 1'b1) begin n_done++; done_cyc = cyc; end
         if (es_we === 1'b1) begin e_swe++; e_mask[es_a] = 1'b1; e_last_cyc = cyc; end
         if (ec_we === 1'b1) e_cwe++;
         if (e_done === 1'b1) begin e_ndone++; e_done_cyc = cyc; end
      end
      @(posedge clk);
      if (live) begin
         if (s_we === 1'b1) sgpr_rf[s_a] = s_d;
         if (c_we === 1'b1) core_rf[c_a] = c_d;
         if (es_we === 1'b1) e_sgpr_rf[es_a] = es_d;
      end
      cyc++;
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         if (done === 1'b1) ok = 1'b1;
      end
      tick();
   endtask

   task automatic fill_random();
      for (int k = 0; k < 32; k++) begin
         core_rf[k] = $urandom;
         sgpr_rf[k] = $urandom;
      end
   endtask

   // Reference: a completed sequence copies R1..R31 in the chosen direction.
   task automatic model_copy(input bit rb);
      for (int k = 0; k < 32; k++) begin
         exp_core[k] = core_rf[k];
         exp_sgpr[k] = sgpr_rf[k];
      end
      for (int k = 1; k < 32; k++) begin
         if (rb) exp_core[k] = sgpr_rf[k];
         else    exp_sgpr[k] = core_rf[k];
      end
   endtask

   function automatic int count_diffs();
      int e = 0;
      for (int k = 0; k < 32; k++) begin
         if (core_rf[k] !== exp_core[k]) e++;
         if (sgpr_rf[k] !== exp_sgpr[k]) e++;
      end
      return e;
   endfunction

   task automatic pulse_req(input bit ck, input bit rb);
      ckpt_req = ck; rb_req = rb;
      tick();
      ckpt_req = 1'b0; rb_req = 1'b0;
   endtask

   task automatic clear_marks();
      sw_mask = '0; cw_mask = '0; e_mask = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ckpt_req = 0; rb_req = 0; halt_ack = 0;
      e_ckpt_req = 0; e_rb_req = 0; e_halt_ack = 0;
      clear_marks();
      fill_random();
      for (int k = 0; k < 32; k++) begin e_core_rf[k] = $urandom; e_sgpr_rf[k] = $urandom; end
      #1;
      n_chk++; if (busy !== 1'b0 || halt_req !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_ctrl: busy/halt/done=%b%b%b want 000", busy, halt_req, done); else n_pass++;
      n_chk++; if ({core_we, sgpr_we, core_raddr, core_waddr, sgpr_raddr, sgpr_waddr} !== '0)
         $display("FAIL reset_addr_we: got %h want 0", {core_we, sgpr_we, core_raddr, core_waddr, sgpr_raddr, sgpr_waddr}); else n_pass++;
      n_chk++; if ({core_wdata, sgpr_wdata} !== '0)
         $display("FAIL reset_data: got %h want 0", {core_wdata, sgpr_wdata}); else n_pass++;
      ckpt_req = 1'b1; halt_ack = 1'b1;
      ticks(3);
      n_chk++; if (busy !== 1'b0 || n_swe != 0)
         $display("FAIL reset_hold: busy=%b writes=%0d want 0/0", busy, n_swe); else n_pass++;
      ckpt_req = 1'b0; halt_ack = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      ticks(2);
   endtask

   task automatic test_checkpoint();
      int b_swe, b_cwe, b_done, b_swe0; bit ok;
      for (int k = 0; k < 32; k++) begin
         core_rf[k] = 32'h1000_0000 + k;
         sgpr_rf[k] = $urandom;
      end
      core_rf[0] = 32'hDEAD_BEEF;
      sgpr_rf[0] = '0;
      model_copy(1'b0);
      clear_marks();
      b_swe = n_swe; b_cwe = n_cwe; b_done = n_done; b_swe0 = n_swe0;
      pulse_req(1'b1, 1'b0);
      n_chk++; if (halt_req !== 1'b1 || busy !== 1'b1)
         $display("FAIL ckpt_halt: halt/busy=%b%b want 11", halt_req, busy); else n_pass++;
      tick();
      halt_ack = 1'b1;
      wait_done(ok);
      halt_ack = 1'b0;
      ticks(4);
      n_chk++; if (!ok) $display("FAIL ckpt_timeout: done_o not seen within bound"); else n_pass++;
      n_chk++; if (count_diffs() != 0)
         $display("FAIL ckpt_data: %0d words differ from model", count_diffs()); else n_pass++;
      n_chk++; if (sgpr_rf[0] !== 32'h0)
         $display("FAIL ckpt_r0: shadow R0=%h want 0", sgpr_rf[0]); else n_pass++;
      n_chk++; if (n_swe - b_swe != 31 || n_cwe - b_cwe != 0 || n_swe0 != b_swe0)
         $display("FAIL ckpt_writes: sgpr=%0d core=%0d r0=%0d want 31/0/0", n_swe - b_swe, n_cwe - b_cwe, n_swe0 - b_swe0); else n_pass++;
      n_chk++; if (sw_mask !== 32'hFFFF_FFFE)
         $display("FAIL ckpt_addrs: mask=%h want fffffffe", sw_mask); else n_pass++;
      n_chk++; if (n_done - b_done != 1 || done_cyc != last_we_cyc + 1)
         $display("FAIL ckpt_done: pulses=%0d done_cyc=%0d last_we=%0d want 1 and last+1", n_done - b_done, done_cyc, last_we_cyc); else n_pass++;
      n_chk++; if (busy !== 1'b0 || halt_req !== 1'b0)
         $display("FAIL ckpt_idle: busy/halt=%b%b want 00", busy, halt_req); else n_pass++;
   endtask

   task automatic test_rollback();
      int b_swe, b_cwe, b_cwe0, b_done; bit ok;
      for (int k = 0; k < 32; k++) begin
         sgpr_rf[k] = 32'hA5A5_0000 + k;
         core_rf[k] = $urandom;
      end
      core_rf[0] = '0;
      model_copy(1'b1);
      clear_marks();
      b_swe = n_swe; b_cwe = n_cwe; b_cwe0 = n_cwe0; b_done = n_done;
      pulse_req(1'b0, 1'b1);
      halt_ack = 1'b1;
      wait_done(ok);
      halt_ack = 1'b0;
      ticks(3);
      n_chk++; if (!ok) $display("FAIL rb_timeout: done_o not seen within bound"); else n_pass++;
      n_chk++; if (count_diffs() != 0)
         $display("FAIL rb_data: %0d words differ from model", count_diffs()); else n_pass++;
      n_chk++; if (n_swe != b_swe || n_cwe0 != b_cwe0 || n_cwe - b_cwe != 31)
         $display("FAIL rb_writes: sgpr=%0d core_r0=%0d core=%0d want 0/0/31", n_swe - b_swe, n_cwe0 - b_cwe0, n_cwe - b_cwe); else n_pass++;
      n_chk++; if (n_done - b_done != 1)
         $display("FAIL rb_done: pulses=%0d want 1", n_done - b_done); else n_pass++;
   endtask

   task automatic test_simultaneous();
      int b_swe, b_done; bit ok;
      fill_random();
      model_copy(1'b1);
      b_swe = n_swe; b_done = n_done;
      pulse_req(1'b1, 1'b1);
      halt_ack = 1'b1;
      ticks(5);
      pulse_req(1'b1, 1'b0);
      ticks(3);
      pulse_req(1'b0, 1'b1);
      wait_done(ok);
      halt_ack = 1'b0;
      ticks(40);
      n_chk++; if (!ok) $display("FAIL both_timeout: done_o not seen within bound"); else n_pass++;
      n_chk++; if (count_diffs() != 0 || n_swe != b_swe)
         $display("FAIL both_rb_wins: diffs=%0d sgpr writes=%0d want 0/0", count_diffs(), n_swe - b_swe); else n_pass++;
      n_chk++; if (n_done - b_done != 1 || busy !== 1'b0)
         $display("FAIL both_single: pulses=%0d busy=%b want 1/0", n_done - b_done, busy); else n_pass++;
   endtask

   task automatic test_halt_wait();
      int b_w, b_done; bit ok;
      fill_random();
      model_copy(1'b0);
      b_w = n_swe + n_cwe; b_done = n_done;
      pulse_req(1'b1, 1'b0);
      ticks(100);
      n_chk++; if (halt_req !== 1'b1 || busy !== 1'b1 || n_swe + n_cwe != b_w)
         $display("FAIL wait_hold: halt/busy=%b%b writes=%0d want 11/0", halt_req, busy, n_swe + n_cwe - b_w); else n_pass++;
      halt_ack = 1'b1;
      tick();
      tick();
      halt_ack = 1'b0;
      wait_done(ok);
      n_chk++; if (!ok || count_diffs() != 0 || n_done - b_done != 1)
         $display("FAIL wait_finish: ok=%0d diffs=%0d pulses=%0d want 1/0/1", ok, count_diffs(), n_done - b_done); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int b_done, errs; bit seen; bit ok;
      logic [DW-1:0] old_sh [0:31];
      fill_random();
      for (int k = 0; k < 32; k++) old_sh[k] = sgpr_rf[k];
      clear_marks();
      b_done = n_done;
      pulse_req(1'b1, 1'b0);
      halt_ack = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (sgpr_we === 1'b1 && sgpr_waddr === 5'd10) seen = 1'b1;
      end
      n_chk++; if (!seen) $display("FAIL mid_reach: address 10 never reached"); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++; if ({halt_req, busy, done, core_we, sgpr_we, sgpr_waddr, core_waddr, sgpr_wdata, core_wdata} !== '0)
         $display("FAIL mid_outputs: got %h want 0", {halt_req, busy, done, core_we, sgpr_we, sgpr_waddr, core_waddr, sgpr_wdata, core_wdata}); else n_pass++;
      ticks(3);
      halt_ack = 1'b0;
      errs = 0;
      for (int k = 1; k < 32; k++) begin
         if (k < 10 && sgpr_rf[k] !== core_rf[k]) errs++;
         if (k >= 10 && sgpr_rf[k] !== old_sh[k]) errs++;
      end
      n_chk++; if (errs != 0 || sw_mask !== 32'h0000_03FE)
         $display("FAIL mid_partial: errs=%0d mask=%h want 0/000003fe", errs, sw_mask); else n_pass++;
      n_chk++; if (n_done != b_done)
         $display("FAIL mid_no_done: pulses=%0d want 0", n_done - b_done); else n_pass++;
      model_copy(1'b0);
      rst_n = 1'b1;
      ckpt_req = 1'b1;
      tick();
      ckpt_req = 1'b0;
      n_chk++; if (busy !== 1'b1 || halt_req !== 1'b1)
         $display("FAIL mid_first_edge: busy/halt=%b%b want 11", busy, halt_req); else n_pass++;
      halt_ack = 1'b1;
      wait_done(ok);
      halt_ack = 1'b0;
      n_chk++; if (!ok || count_diffs() != 0 || n_done - b_done != 1)
         $display("FAIL mid_recover: ok=%0d diffs=%0d pulses=%0d want 1/0/1", ok, count_diffs(), n_done - b_done); else n_pass++;
   endtask

   task automatic test_random();
      bit rb, ok; int dly, b_done;
      for (int it = 0; it < 6; it++) begin
         fill_random();
         rb  = $urandom_range(0, 1);
         dly = $urandom_range(0, 6);
         model_copy(rb);
         b_done = n_done;
         pulse_req(!rb, rb);
         ticks(dly);
         halt_ack = 1'b1;
         wait_done(ok);
         halt_ack = 1'b0;
         ticks($urandom_range(0, 3));
         n_chk++; if (!ok || count_diffs() != 0 || n_done - b_done != 1)
            $display("FAIL rand_%0d: mode=%0d ok=%0d diffs=%0d pulses=%0d want ok/0/1", it, rb, ok, count_diffs(), n_done - b_done); else n_pass++;
      end
   endtask

   task automatic test_rv32e();
      int errs; bit ok;
      for (int k = 0; k < 32; k++) begin e_core_rf[k] = $urandom; e_sgpr_rf[k] = $urandom; end
      e_sgpr_rf[0] = '0;
      for (int k = 0; k < 32; k++) begin exp_core[k] = e_core_rf[k]; exp_sgpr[k] = e_sgpr_rf[k]; end
      for (int k = 1; k < 16; k++) exp_sgpr[k] = e_core_rf[k];
      clear_marks();
      e_swe = 0; e_cwe = 0; e_ndone = 0;
      e_ckpt_req = 1'b1;
      tick();
      e_ckpt_req = 1'b0;
      tick();
      e_halt_ack = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         if (e_done === 1'b1) ok = 1'b1;
      end
      ticks(4);
      e_halt_ack = 1'b0;
      errs = 0;
      for (int k = 0; k < 32; k++) if (e_sgpr_rf[k] !== exp_sgpr[k] || e_core_rf[k] !== exp_core[k]) errs++;
      n_chk++; if (!ok) $display("FAIL e_timeout: done_o not seen within bound"); else n_pass++;
      n_chk++; if (e_swe != 15 || e_cwe != 0 || e_mask !== 32'h0000_FFFE)
         $display("FAIL e_writes: sgpr=%0d core=%0d mask=%h want 15/0/0000fffe", e_swe, e_cwe, e_mask); else n_pass++;
      n_chk++; if (errs != 0) $display("FAIL e_data: %0d words differ from model", errs); else n_pass++;
      n_chk++; if (e_ndone != 1 || e_done_cyc != e_last_cyc + 1)
         $display("FAIL e_done: pulses=%0d done_cyc=%0d last_we=%0d want 1 and last+1", e_ndone, e_done_cyc, e_last_cyc); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_checkpoint();
      test_rollback();
      test_simultaneous();
      test_halt_wait();
      test_reset_mid();
      test_random();
      test_rv32e();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sgpr_sync.md
SGPR_SYNC -- requirements
Module: sgpr_sync

Interface
REQ-001 SHALL have parameter RV32E, default 0; 1 selects 16-entry register file (ADDR_WIDTH=4), else 32-entry (ADDR_WIDTH=5); NUM_WORDS=2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32; register word width.
REQ-003 SHALL have ports (one per line; clock and reset first):
- clk  input  1  clock; reset rst_n, asynchronous, active-low.
- rst_n  input  1  asynchronous active-low reset.
- ckpt_req_i  input  1  request checkpoint (core RF -> shadow GPR).
- rb_req_i  input  1  request rollback (shadow GPR -> core RF).
- halt_req_o  output  1  request core pipeline halt.
- halt_ack_i  input  1  core halted, RF quiescent.
- busy_o  output  1  sequence in progress.
- done_o  output  1  one-cycle completion pulse.
- core_raddr_o  output  5  core RF read address.
- core_rdata_i  input  DATA_WIDTH  core RF read data (combinational).
- core_waddr_o  output  5  core RF write address.
- core_wdata_o  output  DATA_WIDTH  core RF write data.
- core_we_o  output  1  core RF write enable.
- sgpr_raddr_o  output  5  shadow GPR read address.
- sgpr_rdata_i  input  DATA_WIDTH  shadow GPR read data (combinational).
- sgpr_waddr_o  output  5  shadow GPR write address.
- sgpr_wdata_o  output  DATA_WIDTH  shadow GPR write data.
- sgpr_we_o  output  1  shadow GPR write enable.

Function
REQ-004 SHALL implement FSM states IDLE, HALT, COPY, DONE.
REQ-005 IDLE: ckpt_req_i or rb_req_i sampled high SHALL latch mode and go to HALT; rb_req_i SHALL win when both high.
REQ-006 Requests while not IDLE SHALL be ignored; no queuing.
REQ-007 HALT: halt_req_o=1; on halt_ack_i sampled high SHALL go to COPY with address counter=1; waits indefinitely otherwise.
REQ-008 COPY: halt_req_o=1; counter value drives all four address outputs; one register per cycle; R0 never read or written.
REQ-009 COPY checkpoint: sgpr_we_o=1, sgpr_wdata_o=core_rdata_i, core_we_o=0.
REQ-010 COPY rollback: core_we_o=1, core_wdata_o=sgpr_rdata_i, sgpr_we_o=0.
REQ-011 Counter SHALL increment each COPY cycle; at NUM_WORDS-1 SHALL go to DONE (no wrap to 0); COPY lasts exactly NUM_WORDS-1 cycles (31, or 15 with RV32E).
REQ-012 Counter width SHALL be ADDR_WIDTH; address outputs zero-extended to 5 bits.
REQ-013 DONE: done_o=1 for exactly one cycle, halt_req_o=0, both we=0; then IDLE.
REQ-014 halt_ack_i deassertion during COPY SHALL be ignored; sequence completes.
REQ-015 busy_o SHALL be 1 in HALT, COPY, DONE; 0 in IDLE.
REQ-016 Write enables SHALL be 0 outside COPY; address/data outputs are don't-care when enables are 0 but SHALL be driven (no X).
REQ-017 Core-to-shadow data path SHALL be combinational (no added latency) so each write lands in the same cycle as its read.

Reset
REQ-018 rst_n low SHALL force IDLE, counter=0, mode=checkpoint, all outputs 0, immediately and independent of clk.
REQ-019 Reset mid-COPY SHALL abort; registers already copied stay written, no further writes; no done_o pulse.
REQ-020 After rst_n release first request SHALL be accepted on the first rising clk edge.

Verification
REQ-021 Checkpoint: core RF Rk=0x1000_0000+k, ckpt_req_i pulse, halt_ack_i 2 cycles later -> shadow Rk=0x1000_0000+k for k=1..31, shadow R0 reads 0, done_o one pulse, 31 sgpr_we_o cycles.
REQ-022 Rollback: shadow Rk=0xA5A5_0000+k, rb_req_i pulse -> core Rk match for k=1..31, sgpr_we_o never high, core_we_o never at address 0.
REQ-023 Simultaneous ckpt_req_i and rb_req_i -> rollback performed; second request during busy_o -> ignored, single done_o.
REQ-024 halt_ack_i held low 100 cycles -> halt_req_o high, busy_o high, zero writes; ack then -> normal completion.
REQ-025 rst_n low at COPY address 10 -> outputs 0 immediately, addresses 1..9 written only, no done_o; new checkpoint after release completes all 31.
REQ-026 RV32E=1 checkpoint -> exactly 15 writes (addresses 1..15), done_o at cycle after address 15.
